mem_access_stage: RTL

- Memory-stage controller, directly upstream of the Mem/WB pipeline buffer.
- Executes 16-bit (narrow) or 32-bit (wide, two-word) loads, stores, pushes and pops against a 16-bit-wide synchronous data memory.
- Maintains the stack pointer and stalls the pipeline for multi-cycle accesses.
- Its outputs feed the Mem/WB buffer's i_WB / i_MemData / i_alu / i_Rdst.

---
 rtl/mem_access_stage_if.sv | 27 ++
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the Mem stage: word address, write data/strobe, read strobe
// and read data returned one cycle after the read strobe.
interface mem_access_stage_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;
  logic              m_we;
  logic              m_re;
  logic [15:0]       m_rdata;

  modport master (
    output m_addr,
    output m_wdata,
    output m_we,
    output m_re,
    input  m_rdata
  );

  modport slave (
    input  m_addr,
    input  m_wdata,
    input  m_we,
    input  m_re,
    output m_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Mem-stage controller: narrow/wide loads, stores, pushes and pops on a 16-bit memory,
// with stack pointer and stall generation. Optional stack bounds check: STACK_GUARD_EN.
module mem_access_stage #(
  parameter int                ADDR_W  = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_mem_rd,
  input  logic               i_mem_wr,
  input  logic               i_sp,
  input  logic               i_wide,
  input  logic [15:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_WB,
  input  logic [15:0]        i_alu,
  input  logic [2:0]         i_Rdst,
  mem_access_stage_if.master mem,
  output logic               o_stall,
  output logic [3:0]         o_WB,
  output logic [31:0]        o_MemData,
  output logic [15:0]        o_alu,
  output logic [2:0]         o_Rdst,
  output logic               o_stack_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    WR2  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t            state_r;
  state_t            next_s;
  logic [ADDR_W-1:0] sp_r;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] base_hi_s;
  logic [ADDR_W-1:0] words_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       hi_r;
  logic [15:0]       wdata_s;
  logic [31:0]       memdata_s;
  logic              active_s;
  logic              we_s;
  logic              re_s;
  logic              stall_s;
  logic              done_s;
  logic              fault_s;
  logic              fault_hit_s;
  logic              unused_s;

  assign unused_s  = ^i_addr[15:ADDR_W];
  assign active_s  = i_valid & (i_mem_rd | i_mem_wr);
  assign words_s   = i_wide ? TWO : ONE;
  assign base_hi_s = base_s + ONE;

  // Base address: stack ops address relative to SP (push below, pop above), others use the ALU result
  always_comb begin
    base_s = i_addr[ADDR_W-1:0];
    if (i_sp) begin
      if (i_mem_wr) begin
        base_s = i_wide ? (sp_r - ONE) : sp_r;
      end else begin
        base_s = sp_r + ONE;
      end
    end else begin
      base_s = i_addr[ADDR_W-1:0];
    end
  end

`ifdef STACK_GUARD_EN
  logic [ADDR_W-1:0] used_s;
  logic              err_r;

  assign used_s  = SP_INIT - sp_r;
  assign fault_s = active_s & i_sp & (i_mem_wr ? (sp_r < words_s) : (used_s < words_s));

  // Sticky stack fault flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (fault_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign o_stack_err = err_r;
`else
  assign fault_s     = 1'b0;
  assign o_stack_err = 1'b0;
`endif

  // Next-state and strobe decode; inputs stay stable while stalled so they still describe the op
  always_comb begin
    next_s      = state_r;
    we_s        = 1'b0;
    re_s        = 1'b0;
    addr_s      = base_s;
    wdata_s     = 16'h0000;
    stall_s     = 1'b0;
    memdata_s   = 32'h0000_0000;
    done_s      = 1'b0;
    fault_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!active_s) begin
          next_s = IDLE;
        end else if (fault_s) begin
          fault_hit_s = 1'b1;
        end else if (i_mem_wr) begin
          we_s = 1'b1;
          if (i_wide) begin
            wdata_s = i_wdata[31:16];
            stall_s = 1'b1;
            next_s  = WR2;
          end else begin
            wdata_s = i_wdata[15:0];
            done_s  = 1'b1;
          end
        end else begin
          re_s    = 1'b1;
          stall_s = 1'b1;
          next_s  = i_wide ? RD1 : RD2;
        end
      end
      RD1: begin
        re_s    = 1'b1;
        addr_s  = base_hi_s;
        stall_s = 1'b1;
        next_s  = RD2;
      end
      RD2: begin
        memdata_s = i_wide ? {hi_r, mem.m_rdata} : {16'h0000, mem.m_rdata};
        done_s    = 1'b1;
        next_s    = IDLE;
      end
      WR2: begin
        we_s    = 1'b1;
        addr_s  = base_hi_s;
        wdata_s = i_wdata[15:0];
        done_s  = 1'b1;
        next_s  = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, stack pointer and upper-word holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sp_r    <= SP_INIT;
      hi_r    <= 16'h0000;
    end else begin
      state_r <= next_s;
      if (done_s && i_sp) begin
        sp_r <= i_mem_wr ? (sp_r - words_s) : (sp_r + words_s);
      end else begin
        sp_r <= sp_r;
      end
      if (state_r == RD1) begin
        hi_r <= mem.m_rdata;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign mem.m_we    = we_s & ~rst;
  assign mem.m_re    = re_s & ~rst;
  assign mem.m_addr  = addr_s;
  assign mem.m_wdata = wdata_s;
  assign o_stall     = stall_s & ~rst;
  assign o_WB        = (o_stall | fault_hit_s) ? 4'h0 : i_WB;
  assign o_MemData   = memdata_s;
  assign o_alu       = i_alu;
  assign o_Rdst      = i_Rdst;

endmodule
